// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN inference sequencer and its image unpacker.
package snn_pkg;

   localparam int NUM_BYTES  = 98;
   localparam int INPUT_BITS = 784;
   localparam int ADDR_W     = $clog2(INPUT_BITS);
   localparam int BYTE_CNT_W = $clog2(NUM_BYTES);

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_ERR  = 8'h3F;

   typedef enum logic [2:0] {
      WAIT_BYTE,
      UNPACK,
      START,
      WAIT_DONE,
      TX_REQ,
      TX_WAIT
   } seq_state_e;

endpackage

// File: rtl/snn_seq_if.sv
// Byte-stream, input-RAM, core and transmitter signals of the sequencer, bundled as one port.
interface snn_seq_if;
   import snn_pkg::*;

   logic              rx_vld;
   logic [7:0]        rx_data;
   logic              rx_rdy;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_d;
   logic              ram_we;
   logic [ADDR_W-1:0] core_addr;
   logic              core_start;
   logic              core_done;
   logic [3:0]        core_digit;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic [3:0]        digit;
   logic              err;

   modport master (
      input  rx_vld, rx_data, core_addr, core_done, core_digit, tx_busy,
      output rx_rdy, ram_addr, ram_d, ram_we, core_start, tx_start, tx_data, digit, err
   );

   modport slave (
      output rx_vld, rx_data, core_addr, core_done, core_digit, tx_busy,
      input  rx_rdy, ram_addr, ram_d, ram_we, core_start, tx_start, tx_data, digit, err
   );

endinterface

// File: rtl/snn_unpack.sv
// Serialises each image byte LSB-first into input-RAM writes at address 8*byte_cnt + bit_cnt.
module snn_unpack
   import snn_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [7:0]        data,
   input  logic              step,
   input  logic              clr,
   output logic [ADDR_W-1:0] addr,
   output logic              bit_d,
   output logic              byte_done,
   output logic              last_byte
);

   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);

   logic [7:0]            shift;
   logic [2:0]            bit_cnt;
   logic [BYTE_CNT_W-1:0] byte_cnt;

   // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
      end else if (load) begin
         shift   <= data;
         bit_cnt <= '0;
      end else if (step) begin
         shift   <= {1'b0, shift[7:1]};
         bit_cnt <= bit_cnt + 3'd1;
         if (byte_done) byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      end else if (clr) begin
         byte_cnt <= '0;
      end
   end

   assign byte_done = (bit_cnt == 3'd7);
   assign last_byte = (byte_cnt == LAST_BYTE);
   assign addr      = {byte_cnt, bit_cnt};
   assign bit_d     = shift[0];

endmodule

// File: rtl/snn_seq.sv
// SNN inference sequencer: load image, start core, await result, send ASCII digit.
// Optional core watchdog enabled by defining SNN_SEQ_TIMEOUT_EN.
module snn_seq
   import snn_pkg::*;
`ifdef SNN_SEQ_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYC = 2000000
)
`endif
(
   input logic        clk,
   input logic        rst_n,
   snn_seq_if.master  bus
);

   seq_state_e        state, state_nxt;
   logic              rx_xfer;
   logic              timeout;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_d;
   logic              byte_done;
   logic              last_byte;
   logic [3:0]        digit_q;
   logic [7:0]        tx_data_q;

   assign rx_xfer = (state == WAIT_BYTE) && bus.rx_vld;

   snn_unpack u_unpack (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (rx_xfer),
      .data      (bus.rx_data),
      .step      (state == UNPACK),
      .clr       (state == START),
      .addr      (ld_addr),
      .bit_d     (ld_d),
      .byte_done (byte_done),
      .last_byte (last_byte)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_BYTE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         WAIT_BYTE: if (bus.rx_vld)                  state_nxt = UNPACK;
         UNPACK:    if (byte_done)                   state_nxt = last_byte ? START : WAIT_BYTE;
         START:                                      state_nxt = WAIT_DONE;
         WAIT_DONE: if (bus.core_done || timeout)    state_nxt = TX_REQ;
         TX_REQ:    if (!bus.tx_busy)                state_nxt = TX_WAIT;
         TX_WAIT:                                    state_nxt = WAIT_BYTE;
         default:                                    state_nxt = WAIT_BYTE;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      bus.rx_rdy     = 1'b0;
      bus.ram_we     = 1'b0;
      bus.ram_d      = 1'b0;
      bus.ram_addr   = bus.core_addr;
      bus.core_start = 1'b0;
      bus.tx_start   = 1'b0;
      unique case (state)
         WAIT_BYTE: bus.rx_rdy = 1'b1;
         UNPACK: begin
            bus.ram_we   = 1'b1;
            bus.ram_d    = ld_d;
            bus.ram_addr = ld_addr;
         end
         START:     bus.core_start = 1'b1;
         TX_REQ:    bus.tx_start   = !bus.tx_busy;
         default:   ;
      endcase
   end

   // Result byte is formed on entry to TX_REQ so it is stable for the whole request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q   <= '0;
         tx_data_q <= '0;
      end else if (state == WAIT_DONE) begin
         if (bus.core_done) begin
            digit_q   <= bus.core_digit;
            tx_data_q <= ASCII_ZERO + {4'h0, bus.core_digit};
         end else if (timeout) begin
            tx_data_q <= ASCII_ERR;
         end
      end
   end

   assign bus.digit   = digit_q;
   assign bus.tx_data = tx_data_q;

`ifdef SNN_SEQ_TIMEOUT_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         wd_cnt <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
         if (timeout) err_q <= 1'b1;
      end
   end

   // A core_done arriving on the final watchdog cycle takes priority over the timeout.
   assign timeout = (state == WAIT_DONE) && !bus.core_done && (wd_cnt == WD_LAST);
   assign bus.err = err_q;
`else
   assign timeout = 1'b0;
   assign bus.err = 1'b0;
`endif

endmodule
